uart_tx_scheduler: RTL and testbench
====================================

# uart_tx_scheduler

Round-robin scheduler that shares the single `uart_tx` serializer between `NUM_REQ` byte requesters, such as the button-driven test pattern, an RX echo path and a status reporter. It sits between the requesters and `uart_tx` inside the transceiver top level. It accepts one byte at a time over a valid/ready handshake, issues it to `uart_tx` as a one-cycle `tx_data_valid` pulse, and tracks the serializer's ready/busy status until the frame completes. A guard timer aborts the transfer if the serializer never accepts it.

## Interface
- `NUM_REQ`, default 3: number of requesters, 2..16.
- `WORD_WIDTH`, default 8: byte width, must equal `uart_tx` `WORD_WIDTH`.
- `ACCEPT_TIMEOUT`, default 16: cycles allowed for `tx_ready` to fall after the issue pulse, must be ≥ 2.
- `clock` input 1: system clock.
- `rst` input 1: reset, asynchronous, active-high.
- `req_valid` input NUM_REQ: bit i high means requester i holds a byte.
- `req_data` input NUM_REQ*WORD_WIDTH: byte of requester i is at `[i*WORD_WIDTH +: WORD_WIDTH]`.
- `req_ready` output NUM_REQ: one-cycle pulse on bit i when requester i's byte is latched.
- `tx_ready` input 1: from `uart_tx`, high when the serializer is idle.
- `tx_data_valid` output 1: one-cycle issue pulse to `uart_tx`.
- `tx_data_in` output WORD_WIDTH: byte to `uart_tx`, stable from the issue cycle until the next latch.
- `grant_id` output $clog2(NUM_REQ): requester currently or last served.
- `busy` output 1: high in every state except IDLE.
- `err_timeout` output 1: one-cycle pulse when the accept guard expires.

## Operation
- States: IDLE, ISSUE, WAIT_ACCEPT, WAIT_DONE.
- **IDLE:**
  - Grant condition: `tx_ready`=1 and any `req_valid`.
  - Selection: pick the first valid requester scanning upward from `last_grant+1`, wrapping modulo NUM_REQ.
  - On grant: latch the requester's byte, pulse `req_ready[i]`, update `grant_id` and `last_grant`, go to ISSUE.
  - If `tx_ready`=0, stay in IDLE and grant nothing.
- **ISSUE:** assert `tx_data_valid` for exactly one cycle, clear the guard counter, go to WAIT_ACCEPT.
- **WAIT_ACCEPT:**
  - `tx_ready`=0: go to WAIT_DONE.
  - Otherwise increment the guard counter.
  - When the counter reaches ACCEPT_TIMEOUT-1 with `tx_ready` still high: pulse `err_timeout`, go to IDLE. The byte is dropped and not retried.
- **WAIT_DONE:** when `tx_ready` rises, go to IDLE, or to the tag phase (see Configuration).
- Requester obligations: hold `req_valid` and data stable until `req_ready`. Deasserting `req_valid` before grant is legal and withdraws the request.
- Simultaneous requests: exactly one grant per byte. With all requesters valid continuously, grants cycle 0,1,2,0,…
- Fairness: a requester that asserts `req_valid` in the same cycle another is granted waits for the next IDLE.
- Reset values:
  - State IDLE.
  - `last_grant`=NUM_REQ-1, so requester 0 wins first.
  - All outputs 0, including `tx_data_in` and `grant_id`.
- Reset mid-transfer: immediate return to IDLE with outputs cleared. Any byte already being serialized by `uart_tx` is not tracked.
- Guard counter width: $clog2(ACCEPT_TIMEOUT). It saturates and never wraps.

## Timing
- Grant to issue latency: `req_ready` in cycle T, `tx_data_valid` in T+1.
- Minimum spacing between grants: 4 cycles (IDLE→ISSUE→WAIT_ACCEPT→WAIT_DONE→IDLE), plus the serializer frame time.
- All outputs are registered. There are no combinational paths from `req_*` or `tx_ready` to outputs.
- `err_timeout` asserts in cycle T+1+ACCEPT_TIMEOUT relative to the `req_ready` in cycle T.

## Configuration
- Macro: `UART_TX_SCHED_TAG_EN`.
- **Defined:**
  - Each granted byte is preceded by a tag byte {4'hA, grant_id zero-extended to 4 bits}.
  - Sequence: ISSUE(tag)→WAIT_ACCEPT→WAIT_DONE→ISSUE(data)→WAIT_ACCEPT→WAIT_DONE→IDLE, tracked by a `phase` flag. Minimum grant spacing becomes 7 cycles.
  - A timeout on either byte aborts both.
  - `req_ready` still pulses at grant.
  - WORD_WIDTH must be 8.
- **Undefined:** tag logic and the `phase` flag are absent; only data bytes are sent.

## Structure
- Package `uart_sched_pkg` holds:
  - State enum `sched_state_t`.
  - `TAG_NIBBLE` = 4'hA.
  - Function `rr_next(valid, last)`.
- Sub-module `rr_arbiter` (parameter NUM_REQ): combinational, returns the one-hot grant and index from `req_valid` and `last_grant`. The scheduler registers its outputs.

## Test plan
- Reset, then only requester 1 valid with 8'h5A and `tx_ready` model idle:
  - `req_ready`=3'b010 in cycle T.
  - `tx_data_valid` in T+1 with `tx_data_in`=8'h5A.
  - `grant_id`=1.
- All three requesters valid continuously with bytes 8'h10/8'h20/8'h30 → serialized order 10,20,30,10. Exactly one `req_ready` bit per grant.
- `tx_ready` held high after issue (stuck serializer model):
  - `err_timeout` pulses exactly 16 cycles after the issue pulse.
  - State returns to IDLE with `busy`=0.
- `tx_ready`=0 in IDLE with requesters valid → no `req_ready` and no issue until `tx_ready` rises, then grant within 1 cycle.
- `rst` asserted during WAIT_DONE → all outputs 0 the same cycle. After release the next grant goes to requester 0.
- With `UART_TX_SCHED_TAG_EN`, requester 2 sends 8'h41 → `uart_tx` receives 8'hA2 then 8'h41, with a single `req_ready` pulse.

Source files
------------

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and helpers for the uart_tx round-robin scheduler.
// Optional tag-byte framing is enabled with the UART_TX_SCHED_TAG_EN macro.
package uart_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_ISSUE       = 2'd1,
        ST_WAIT_ACCEPT = 2'd2,
        ST_WAIT_DONE   = 2'd3
    } sched_state_t;

    // High nibble of the tag byte that precedes each data byte in tag mode.
    localparam logic [3:0] TAG_NIBBLE = 4'hA;

    // First valid requester scanning upward from last+1, wrapping at num_req.
    // Sized for the largest supported requester count (16); returns last
    // unchanged when nothing is valid.
    function automatic logic [3:0] rr_next(input logic [15:0] valid,
                                           input logic [3:0]  last,
                                           input int          num_req);
        logic [4:0] idx;
        logic       found;
        rr_next = last;
        found   = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            idx = 5'(last) + 5'(k);
            if (int'(idx) >= num_req) begin
                idx = idx - 5'(num_req);
            end
            if (!found && (k <= num_req) && valid[idx[3:0]]) begin
                rr_next = idx[3:0];
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Bundle between the byte requesters / uart_tx and the scheduler.
//
// Handshakes:
//   requester side: a requester raises req_valid[i] with its byte on
//   req_data and holds both until req_ready[i] pulses for one cycle; the
//   byte is latched in that cycle. Dropping req_valid before the pulse
//   withdraws the request.
//   serializer side: tx_data_valid is a one-cycle issue pulse carrying
//   tx_data_in; tx_ready low means uart_tx took the byte and is busy, and
//   its return high marks the end of the frame.
interface uart_tx_scheduler_if #(
    parameter int NUM_REQ    = 3,
    parameter int WORD_WIDTH = 8
);
    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*WORD_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          tx_ready;
    logic                          tx_data_valid;
    logic [WORD_WIDTH-1:0]         tx_data_in;
    logic [IW-1:0]                 grant_id;
    logic                          busy;
    logic                          err_timeout;

    // Drives requests and serializer status (requesters + uart_tx side).
    modport master (
        output req_valid, req_data, tx_ready,
        input  req_ready, tx_data_valid, tx_data_in, grant_id, busy, err_timeout
    );

    // The scheduler itself.
    modport slave (
        input  req_valid, req_data, tx_ready,
        output req_ready, tx_data_valid, tx_data_in, grant_id, busy, err_timeout
    );
endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin picker: one-hot grant and index from the
// current request vector and the last served requester.
module rr_arbiter
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]         i_req_valid,
    input  logic [$clog2(NUM_REQ)-1:0] i_last_grant,
    output logic [NUM_REQ-1:0]         o_grant,
    output logic [$clog2(NUM_REQ)-1:0] o_grant_idx,
    output logic                       o_grant_any
);
    localparam int IW = $clog2(NUM_REQ);

    logic [3:0] w_pick;

    // Rotating-priority scan starting just above the last winner.
    always_comb begin
        w_pick = rr_next(16'(i_req_valid), 4'(i_last_grant), NUM_REQ);
    end

    assign o_grant_idx = IW'(w_pick);
    assign o_grant     = i_req_valid & (NUM_REQ'(1) << w_pick);
    assign o_grant_any = |i_req_valid;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one uart_tx between NUM_REQ requesters.
// Grants one byte at a time, issues it as a one-cycle pulse, follows the
// serializer's ready/busy status and aborts if it never accepts the byte.
// Defining UART_TX_SCHED_TAG_EN prefixes every byte with {4'hA, grant_id}.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int WORD_WIDTH     = 8,
    parameter int ACCEPT_TIMEOUT = 16
) (
    input  logic                      clock,
    input  logic                      rst,
    uart_tx_scheduler_if.slave        bus,
    output sched_state_t              o_dbg_state
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(ACCEPT_TIMEOUT);
    localparam logic [CW-1:0] C_LAST = CW'(ACCEPT_TIMEOUT - 1);

    sched_state_t          r_state;
    logic [NUM_REQ-1:0]    r_req_ready;
    logic                  r_tx_valid;
    logic [WORD_WIDTH-1:0] r_tx_data;
    logic [IW-1:0]         r_grant_id;
    logic [IW-1:0]         r_last_grant;
    logic                  r_busy;
    logic                  r_err;
    logic [CW-1:0]         r_cnt;
`ifdef UART_TX_SCHED_TAG_EN
    logic                  r_phase;      // 0: tag byte in flight, 1: data byte
    logic [WORD_WIDTH-1:0] r_data_hold;
`endif

    logic [NUM_REQ-1:0]    w_grant;
    logic [IW-1:0]         w_grant_idx;
    logic                  w_grant_any;
    logic [WORD_WIDTH-1:0] w_byte;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .i_req_valid  (bus.req_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_grant_idx  (w_grant_idx),
        .o_grant_any  (w_grant_any)
    );

    assign w_byte = bus.req_data[int'(w_grant_idx) * WORD_WIDTH +: WORD_WIDTH];

    // Scheduler FSM; every output is a register updated here.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_req_ready  <= '0;
            r_tx_valid   <= 1'b0;
            r_tx_data    <= '0;
            r_grant_id   <= '0;
            r_last_grant <= IW'(NUM_REQ - 1);
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
            r_cnt        <= '0;
`ifdef UART_TX_SCHED_TAG_EN
            r_phase      <= 1'b0;
            r_data_hold  <= '0;
`endif
        end else begin
            r_req_ready <= '0;
            r_tx_valid  <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.tx_ready && w_grant_any) begin
                        r_req_ready  <= w_grant;
                        r_grant_id   <= w_grant_idx;
                        r_last_grant <= w_grant_idx;
`ifdef UART_TX_SCHED_TAG_EN
                        r_data_hold  <= w_byte;
                        r_tx_data    <= WORD_WIDTH'({TAG_NIBBLE, 4'(w_grant_idx)});
                        r_phase      <= 1'b0;
`else
                        r_tx_data    <= w_byte;
`endif
                        r_busy       <= 1'b1;
                        r_state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_tx_valid <= 1'b1;
                    r_cnt      <= '0;
                    r_state    <= ST_WAIT_ACCEPT;
                end
                ST_WAIT_ACCEPT: begin
                    if (!bus.tx_ready) begin
                        r_state <= ST_WAIT_DONE;
                    end else if (r_cnt == C_LAST) begin
                        // Serializer never took the byte: drop it (and any
                        // remaining byte of the pair) without retry.
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
`ifdef UART_TX_SCHED_TAG_EN
                        r_phase <= 1'b0;
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (bus.tx_ready) begin
`ifdef UART_TX_SCHED_TAG_EN
                        if (!r_phase) begin
                            r_phase   <= 1'b1;
                            r_tx_data <= r_data_hold;
                            r_state   <= ST_ISSUE;
                        end else begin
                            r_phase <= 1'b0;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
`else
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
`endif
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready     = r_req_ready;
    assign bus.tx_data_valid = r_tx_valid;
    assign bus.tx_data_in    = r_tx_data;
    assign bus.grant_id      = r_grant_id;
    assign bus.busy          = r_busy;
    assign bus.err_timeout   = r_err;
    assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: directed steps plus a
// randomized phase, with a simple uart_tx model and a round-robin reference.
module tb_uart_tx_scheduler;
    import uart_sched_pkg::*;

    localparam int N  = 3;
    localparam int W  = 8;
    localparam int TO = 16;
`ifdef UART_TX_SCHED_TAG_EN
    localparam bit TAG = 1'b1;
`else
    localparam bit TAG = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         rst;
    sched_state_t dbg_state;

    uart_tx_scheduler_if #(.NUM_REQ(N), .WORD_WIDTH(W)) bus ();

    uart_tx_scheduler #(
        .NUM_REQ        (N),
        .WORD_WIDTH     (W),
        .ACCEPT_TIMEOUT (TO)
    ) dut (
        .clock       (clock),
        .rst         (rst),
        .bus         (bus.slave),
        .o_dbg_state (dbg_state)
    );

    // Clock / watchdog
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] rx_data_log[$];
    logic [W-1:0] data_arr[N];
    int           m_last;
    bit           hold_valid;
    bit           stuck;
    bit           rx_is_data;
    int           frame_cnt;
    int           n_grants;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: first valid requester above last, modulo N.
    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (last + k) % N;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    task automatic set_data();
        for (int r = 0; r < N; r++) bus.req_data[r*W +: W] = data_arr[r];
    endtask

    // One clock: scoreboard grants, serve the uart_tx model.
    task automatic tick();
        logic [N-1:0] pv;
        logic [W-1:0] eb;
        int           w;
        pv = bus.req_valid;
        @(posedge clock);
        #1;
        if (bus.req_ready !== '0) begin
            w = rr_pick(pv, m_last);
            check("grant_onehot", 32'($countones(bus.req_ready)), 32'd1);
            check("grant_vector", 32'(bus.req_ready), (w < 0) ? 32'd0 : (32'd1 << w));
            check("grant_id", 32'(bus.grant_id), 32'(w));
            if (w >= 0) begin
                if (TAG) exp_q.push_back({4'hA, 4'(w)});
                exp_q.push_back(data_arr[w]);
                m_last = w;
                n_grants++;
                if (!hold_valid) bus.req_valid[w] = 1'b0;
            end
        end
        if (bus.tx_data_valid === 1'b1) begin
            if (!stuck) begin
                check("issue_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    eb = exp_q.pop_front();
                    check("tx_byte", 32'(bus.tx_data_in), 32'(eb));
                end
                if (!TAG || rx_is_data) rx_data_log.push_back(bus.tx_data_in);
                rx_is_data = TAG ? !rx_is_data : 1'b0;
                bus.tx_ready = 1'b0;
                frame_cnt = $urandom_range(1, 6);
            end
        end else if (frame_cnt > 0) begin
            frame_cnt--;
            if (frame_cnt == 0) bus.tx_ready = 1'b1;
        end
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while ((bus.req_valid !== '0 || bus.busy !== 1'b0 || exp_q.size() != 0 || frame_cnt != 0) && t < 500) begin
            tick();
            t++;
        end
        check({tag, "_drained"}, 32'(t < 500), 32'd1);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        bus.tx_ready = 1'b1;
        frame_cnt = 0;
        exp_q.delete();
        m_last = N - 1;
        rx_is_data = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int t;
        int gr0;
        int n_req;
        int n_wd;
        logic [W-1:0] first_exp;

        // Step 1: reset values
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_data = '0;
        bus.tx_ready = 1'b1;
        hold_valid = 1'b0;
        stuck = 1'b0;
        frame_cnt = 0;
        n_grants = 0;
        m_last = N - 1;
        rx_is_data = 1'b0;
        for (int r = 0; r < N; r++) data_arr[r] = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_tx_valid", 32'(bus.tx_data_valid), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data_in), 32'd0);
        check("rst_grant_id", 32'(bus.grant_id), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_err", 32'(bus.err_timeout), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;

        // Step 2: single requester 1 with 8'h5A
        data_arr[1] = 8'h5A;
        set_data();
        bus.req_valid = 3'b010;
        tick();
        check("single_req_ready", 32'(bus.req_ready), 32'b010);
        check("single_no_issue_yet", 32'(bus.tx_data_valid), 32'd0);
        tick();
        first_exp = TAG ? 8'hA1 : 8'h5A;
        check("single_issue", 32'(bus.tx_data_valid), 32'd1);
        check("single_tx_data", 32'(bus.tx_data_in), 32'(first_exp));
        check("single_grant_id", 32'(bus.grant_id), 32'd1);
        check("single_busy", 32'(bus.busy), 32'd1);
        drain("single");
        check("single_rx_count", 32'(rx_data_log.size()), 32'd1);
        if (rx_data_log.size() > 0) check("single_rx_byte", 32'(rx_data_log[0]), 32'h5A);

        // Step 3: all requesters valid continuously from reset
        apply_reset();
        rx_data_log.delete();
        data_arr[0] = 8'h10;
        data_arr[1] = 8'h20;
        data_arr[2] = 8'h30;
        set_data();
        hold_valid = 1'b1;
        gr0 = n_grants;
        bus.req_valid = 3'b111;
        t = 0;
        while (n_grants < gr0 + 4 && t < 300) begin
            tick();
            t++;
        end
        bus.req_valid = '0;
        hold_valid = 1'b0;
        drain("rr");
        check("rr_rx_count", 32'(rx_data_log.size()), 32'd4);
        if (rx_data_log.size() >= 4) begin
            check("rr_byte0", 32'(rx_data_log[0]), 32'h10);
            check("rr_byte1", 32'(rx_data_log[1]), 32'h20);
            check("rr_byte2", 32'(rx_data_log[2]), 32'h30);
            check("rr_byte3", 32'(rx_data_log[3]), 32'h10);
        end

        // Step 4: stuck serializer -> accept timeout
        stuck = 1'b1;
        data_arr[0] = 8'hC3;
        set_data();
        bus.req_valid = 3'b001;
        t = 0;
        while (bus.req_ready === '0 && t < 20) begin
            tick();
            t++;
        end
        check("stuck_grant", 32'(bus.req_ready), 32'b001);
        tick();
        check("stuck_issue", 32'(bus.tx_data_valid), 32'd1);
        for (int i = 1; i < TO; i++) begin
            tick();
            check("stuck_no_early_err", 32'(bus.err_timeout), 32'd0);
            check("stuck_busy", 32'(bus.busy), 32'd1);
        end
        tick();
        check("stuck_err_pulse", 32'(bus.err_timeout), 32'd1);
        check("stuck_idle_busy", 32'(bus.busy), 32'd0);
        check("stuck_idle_state", 32'(dbg_state), 32'(ST_IDLE));
        tick();
        check("stuck_err_one_cycle", 32'(bus.err_timeout), 32'd0);
        exp_q.delete();
        stuck = 1'b0;
        rx_is_data = 1'b0;

        // Step 5: tx_ready low in IDLE blocks grants
        bus.tx_ready = 1'b0;
        data_arr[1] = 8'h66;
        data_arr[2] = 8'h99;
        set_data();
        bus.req_valid = 3'b110;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("blocked_no_grant", 32'(bus.req_ready), 32'd0);
            check("blocked_no_issue", 32'(bus.tx_data_valid), 32'd0);
        end
        bus.tx_ready = 1'b1;
        tick();
        check("unblocked_grant", 32'(bus.req_ready), 32'b010);
        drain("blocked");

        // Step 6: reset during WAIT_DONE, then requester 0 wins
        data_arr[1] = 8'h77;
        set_data();
        bus.req_valid = 3'b010;
        t = 0;
        while (dbg_state !== ST_WAIT_DONE && t < 30) begin
            tick();
            t++;
        end
        check("reached_wait_done", 32'(dbg_state), 32'(ST_WAIT_DONE));
        rst = 1'b1;
        #1;
        check("midrst_req_ready", 32'(bus.req_ready), 32'd0);
        check("midrst_tx_valid", 32'(bus.tx_data_valid), 32'd0);
        check("midrst_tx_data", 32'(bus.tx_data_in), 32'd0);
        check("midrst_grant_id", 32'(bus.grant_id), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_err", 32'(bus.err_timeout), 32'd0);
        check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
        exp_q.delete();
        m_last = N - 1;
        rx_is_data = 1'b0;
        tick();
        rst = 1'b0;
        data_arr[0] = 8'hAB;
        data_arr[2] = 8'hCD;
        set_data();
        bus.req_valid = 3'b101;
        t = 0;
        while (bus.req_ready === '0 && t < 50) begin
            tick();
            t++;
        end
        check("post_rst_grant", 32'(bus.req_ready), 32'b001);
        drain("post_rst");

        // Step 7: randomized requests, withdrawals and frame lengths
        gr0 = n_grants;
        n_req = 0;
        n_wd = 0;
        for (int c = 0; c < 400; c++) begin
            if (c < 300) begin
                for (int r = 0; r < N; r++) begin
                    if (!bus.req_valid[r] && $urandom_range(0, 3) == 0) begin
                        data_arr[r] = W'($urandom);
                        bus.req_valid[r] = 1'b1;
                        n_req++;
                    end else if (bus.req_valid[r] && $urandom_range(0, 15) == 0) begin
                        bus.req_valid[r] = 1'b0;
                        n_wd++;
                    end
                end
                set_data();
            end
            tick();
        end
        drain("random");
        check("random_grant_count", 32'(n_grants - gr0), 32'(n_req - n_wd));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
